// File: rtl/inj_pkg.sv
// Shared types and constants for the instruction stream injector.
package inj_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} inj_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h00000013;

  typedef struct packed {
    logic        last;
    logic [31:0] instr;
  } inj_entry_t;

endpackage

// File: rtl/inj_fifo.sv
// Show-ahead synchronous FIFO holding host instructions and their last flags.
module inj_fifo import inj_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  inj_entry_t               wr_data,
  input  logic                     pop,
  output inj_entry_t               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  inj_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_stream_injector.sv
// Feeds the core's external instruction port from a buffered host stream, then drains with NOPs.
// Defining INJ_PERF_CNT_EN adds the issued_cnt/bubble_cnt counters.
//
// state  | meaning
// IDLE   | core on internal fetch, host may prefill the FIFO
// STREAM | issuing FIFO entries, NOP bubbles when starved
// DRAIN  | last instruction issued, padding with DRAIN_CYCLES NOPs
// DONE   | drain complete, waiting for start
module instr_stream_injector import inj_pkg::*; #(
  parameter int          DEPTH        = 8,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic                   in_last,
  input  logic                   stall_F,
  output logic                   instr_mode,
  output logic [31:0]            instr_ext,
  output logic                   issue_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   done
`ifdef INJ_PERF_CNT_EN
  ,
  output logic [31:0]            issued_cnt,
  output logic [31:0]            bubble_cnt
`endif
);

  localparam int DCW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  inj_state_t     state;
  inj_state_t     state_nxt;
  inj_entry_t     fifo_wr;
  inj_entry_t     fifo_rd;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           load;
  logic           advance;
  logic           start_ok;
  logic           drain_load;
  logic           drain_dec;
  logic           last_seen;
  logic [DCW-1:0] drain_cnt;

  assign push     = in_valid && in_ready;
  assign advance  = !stall_F && (state == STREAM || state == DRAIN);
  assign start_ok = start && (state == IDLE || state == DONE);
  assign fifo_wr  = '{last: in_last, instr: in_instr};

  inj_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (fifo_wr),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // The start edge loads the first word exactly like a STREAM advance does.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    load       = 1'b0;
    drain_load = 1'b0;
    drain_dec  = 1'b0;
    if (start_ok || (state == STREAM && advance)) begin
      load      = 1'b1;
      pop       = !fifo_empty;
      state_nxt = STREAM;
      if (!fifo_empty && fifo_rd.last) begin
        state_nxt  = DRAIN;
        drain_load = 1'b1;
      end
    end else if (state == DRAIN && advance) begin
      if (drain_cnt != '0) begin
        load      = 1'b1;
        drain_dec = 1'b1;
      end else begin
        state_nxt = DONE;
      end
    end
  end

  always_comb begin
    instr_mode = (state != IDLE);
    done       = (state == DONE);
    in_ready   = !fifo_full && !last_seen && (state == IDLE || state == STREAM);
  end

  // drain_cnt counts the NOPs still owed before DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_ext   <= NOP_INSTR;
      issue_valid <= 1'b0;
      drain_cnt   <= '0;
      last_seen   <= 1'b0;
    end else begin
      if (load) begin
        instr_ext   <= pop ? fifo_rd.instr : NOP_INSTR;
        issue_valid <= pop;
      end
      if (drain_load)     drain_cnt <= DCW'(DRAIN_CYCLES);
      else if (drain_dec) drain_cnt <= drain_cnt - 1'b1;
      if (push && in_last) last_seen <= 1'b1;
      else if (start_ok)   last_seen <= 1'b0;
    end
  end

`ifdef INJ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset || start_ok) begin
      issued_cnt <= '0;
      bubble_cnt <= '0;
    end else if (advance && load) begin
      if (pop) issued_cnt <= issued_cnt + 32'd1;
      else     bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
